// File: rtl/dot_scan_ctrl.sv
// Row-scan controller for the 8x8 dot matrix: row select, double-buffered frame word and
// active-low blanked row enables. Optional brightness dimming via `DOT_SCAN_BRIGHT_EN.
module dot_scan_ctrl #(
  parameter int DIV   = 16,
  parameter int BLANK = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [63:0] ld_data,
`ifdef DOT_SCAN_BRIGHT_EN
  input  logic [2:0]  bright,
`endif
  output logic        ld_ready,
  output logic [2:0]  cs,
  output logic [63:0] d,
  output logic [7:0]  row_n,
  output logic        frame_start
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ON   = CW'(BLANK);

  logic          run_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    cs_q, cs_d;
  logic [63:0]   d_q, d_d;
  logic [63:0]   shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic          ld_ready_q;
  logic [7:0]    row_n_q, row_n_d;
  logic          frame_start_q, frame_start_d;
  logic          boundary;
  logic          accept;
  logic          row_on_d;
  logic          lit_en_d;

`ifdef DOT_SCAN_BRIGHT_EN
  logic [2:0] fcnt_q, fcnt_d;
  logic [2:0] bright_q, bright_d;
`endif

  always_comb begin
    boundary = run_q && (cs_q == 3'd7) && (cnt_q == CNT_LAST);
    accept   = ld_valid && !pend_q;

    // Counters sit at 0 for the first clock after reset release so that cycle 0
    // of the scan is the first one showing frame_start.
    cnt_d = cnt_q;
    cs_d  = cs_q;
    if (run_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        cs_d  = cs_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    d_d      = d_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (boundary && pend_q) begin
      d_d    = shadow_q;
      pend_d = 1'b0;
    end else if (accept) begin
      shadow_d = ld_data;
      pend_d   = 1'b1;
    end

    frame_start_d = (cs_d == 3'd0) && (cnt_d == '0);
    row_on_d      = (cnt_d >= CNT_ON);
  end

`ifdef DOT_SCAN_BRIGHT_EN
  always_comb begin
    fcnt_d   = boundary ? fcnt_q + 3'd1 : fcnt_q;
    bright_d = (boundary || !run_q) ? bright : bright_q;
    lit_en_d = (fcnt_d <= bright_d);
  end
`else
  assign lit_en_d = 1'b1;
`endif

  // Enables derived from next-state cs/cnt so the registered output lines up with them.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
      assign row_n_d[gi] = !(lit_en_d && row_on_d && (cs_d == 3'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      cnt_q         <= '0;
      cs_q          <= 3'd0;
      d_q           <= 64'd0;
      shadow_q      <= 64'd0;
      pend_q        <= 1'b0;
      ld_ready_q    <= 1'b1;
      row_n_q       <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      cnt_q         <= cnt_d;
      cs_q          <= cs_d;
      d_q           <= d_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      ld_ready_q    <= !pend_d;
      row_n_q       <= row_n_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef DOT_SCAN_BRIGHT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q   <= 3'd0;
      bright_q <= 3'd7;
    end else begin
      fcnt_q   <= fcnt_d;
      bright_q <= bright_d;
    end
  end
`endif

  assign ld_ready    = ld_ready_q;
  assign cs          = cs_q;
  assign d           = d_q;
  assign row_n       = row_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_dot_scan_ctrl.sv
// Bench for dot_scan_ctrl (DIV=4, BLANK=1): vector table, hand-written corner sequences,
// then random loads checked every cycle against a frame-level reference model.
module tb_dot_scan_ctrl;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [63:0] ld_data = 64'd0;
  logic        ld_ready;
  logic [2:0]  cs;
  logic [63:0] d;
  logic [7:0]  row_n;
  logic        frame_start;
`ifdef DOT_SCAN_BRIGHT_EN
  logic [2:0]  bright = 3'd7;
`endif

  dot_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
`ifdef DOT_SCAN_BRIGHT_EN
    .bright      (bright),
`endif
    .ld_ready    (ld_ready),
    .cs          (cs),
    .d           (d),
    .row_n       (row_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: t is the scan cycle index (-1 = start cycle right after reset release).
  int          t;
  logic [63:0] m_disp, m_shadow;
  logic        m_pend;
  bit          pending;

  localparam logic [63:0] P  = 64'h0123456789ABCDEF;
  localparam logic [63:0] Q4 = 64'hFEDCBA9876543210;
  localparam logic [63:0] B  = 64'h55AA55AA0F0F0F0F;
  localparam logic [63:0] C  = 64'hDEADBEEFCAFEF00D;

  typedef struct {
    int          cyc;
    logic        lv;
    logic [2:0]  cs;
    logic [7:0]  row_n;
    logic        fs;
    logic        rdy;
    logic [63:0] d;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h, expected %h", name, t, act, exp);
  endtask

  task automatic model_reset();
    t        = -1;
    m_disp   = 64'd0;
    m_shadow = 64'd0;
    m_pend   = 1'b0;
    pending  = 1'b0;
  endtask

  task automatic sample();
    logic [2:0] e_cs;
    logic [7:0] e_row;
    logic       e_fs;
    int         cnt, row;
    @(negedge clk);
    if (t < 0) begin
      e_cs = 3'd0; e_row = 8'hFF; e_fs = 1'b0;
    end else begin
      cnt   = t % DIV;
      row   = (t / DIV) % 8;
      e_cs  = 3'(row);
      e_fs  = ((t % FRAME) == 0);
      e_row = (cnt >= BLANK) ? ~(8'h01 << row) : 8'hFF;
    end
    check("m_cs", 64'(cs), 64'(e_cs));
    check("m_row_n", 64'(row_n), 64'(e_row));
    check("m_frame_start", 64'(frame_start), 64'(e_fs));
    check("m_ld_ready", 64'(ld_ready), 64'(!m_pend));
    check("m_d", d, m_disp);
  endtask

  task automatic advance();
    if (t >= 0 && (t % FRAME) == FRAME - 1 && m_pend) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end else if (ld_valid && !m_pend) begin
      m_shadow = ld_data;
      m_pend   = 1'b1;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int c);
    if (pending) advance();
    while (t < c) begin
      sample();
      advance();
    end
    sample();
    pending = 1'b1;
  endtask

  initial begin
    tbl[0] = '{0,  1'b0, 3'd0, 8'hFF, 1'b1, 1'b1, 64'd0};
    tbl[1] = '{1,  1'b0, 3'd0, 8'hFE, 1'b0, 1'b1, 64'd0};
    tbl[2] = '{3,  1'b0, 3'd0, 8'hFE, 1'b0, 1'b1, 64'd0};
    tbl[3] = '{4,  1'b0, 3'd1, 8'hFF, 1'b0, 1'b1, 64'd0};
    tbl[4] = '{5,  1'b1, 3'd1, 8'hFD, 1'b0, 1'b1, 64'd0};
    tbl[5] = '{6,  1'b0, 3'd1, 8'hFD, 1'b0, 1'b0, 64'd0};
    tbl[6] = '{28, 1'b0, 3'd7, 8'hFF, 1'b0, 1'b0, 64'd0};
    tbl[7] = '{31, 1'b0, 3'd7, 8'h7F, 1'b0, 1'b0, 64'd0};
    tbl[8] = '{32, 1'b0, 3'd0, 8'hFF, 1'b1, 1'b1, P};
    tbl[9] = '{33, 1'b0, 3'd0, 8'hFE, 1'b0, 1'b1, P};

    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Scan timing and first load, vector table
    for (int i = 0; i < 10; i++) begin
      at(tbl[i].cyc);
      check("tbl_cs", 64'(cs), 64'(tbl[i].cs));
      check("tbl_row_n", 64'(row_n), 64'(tbl[i].row_n));
      check("tbl_frame_start", 64'(frame_start), 64'(tbl[i].fs));
      check("tbl_ld_ready", 64'(ld_ready), 64'(tbl[i].rdy));
      check("tbl_d", d, tbl[i].d);
      ld_valid = tbl[i].lv;
      ld_data  = tbl[i].lv ? P : 64'd0;
    end

    // Load accepted exactly at a boundary cycle, plus a second load held while pending
    at(63);
    check("bnd_ready", 64'(ld_ready), 64'd1);
    ld_valid = 1'b1; ld_data = Q4;
    at(64);
    check("bnd_no_swap", d, P);
    check("bnd_ready_low", 64'(ld_ready), 64'd0);
    ld_data = B;
    at(80);
    check("held_ignored", 64'(ld_ready), 64'd0);
    at(95);
    check("pre_swap_d", d, P);
    at(96);
    check("swap_d", d, Q4);
    check("ready_back", 64'(ld_ready), 64'd1);
    at(97);
    check("held_accepted", 64'(ld_ready), 64'd0);
    ld_valid = 1'b0;
    at(127);
    check("b_not_yet", d, Q4);
    at(128);
    check("b_shown", d, B);

    // Asynchronous reset mid-row 5 with a frame pending
    at(130);
    ld_valid = 1'b1; ld_data = C;
    at(131);
    ld_valid = 1'b0;
    at(149);
    check("row5_cs", 64'(cs), 64'd5);
    check("row5_pend", 64'(ld_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_cs", 64'(cs), 64'd0);
    check("rst_d", d, 64'd0);
    check("rst_row_n", 64'(row_n), 64'hFF);
    check("rst_ready", 64'(ld_ready), 64'd1);
    check("rst_frame_start", 64'(frame_start), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    at(0);
    check("resume_fs", 64'(frame_start), 64'd1);
    at(4);
    check("resume_cs", 64'(cs), 64'd1);

    // Random loads against the model
    advance();
    pending = 1'b0;
    for (int i = 0; i < 600; i++) begin
      sample();
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_data  = {$urandom, $urandom};
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
